// File: rtl/boid_frame_writer.sv
// boid_frame_writer: once per frame, erases last frame's boid squares from the
// boid bitmap and redraws each boid at its freshly fetched position.
module boid_frame_writer #(
  parameter int unsigned NUM_BOIDS           = 16,
  parameter int unsigned BOID_SIZE           = 2,
  parameter int unsigned VIDEO_WIDTH         = 640,
  parameter int unsigned VIDEO_HEIGHT        = 480,
  parameter int unsigned PIXEL_ADDRESS_WIDTH = 20,
  localparam int unsigned IDX_W = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           screenEnd,
  output logic [IDX_W-1:0]               pos_read_addr,
  input  logic [9:0]                     pos_read_x,
  input  logic [8:0]                     pos_read_y,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] boid_write_address,
  output logic                           boid_write_data,
  output logic                           boid_write_en,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun
);

  localparam int unsigned D_W   = (BOID_SIZE > 1) ? $clog2(BOID_SIZE) : 1;
  localparam int unsigned PAW   = PIXEL_ADDRESS_WIDTH;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned XS_W  = X_W + 1;
  localparam int unsigned YS_W  = Y_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERASE = 3'd1,
    S_FETCH = 3'd2,
    S_LATCH = 3'd3,
    S_DRAW  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_se_q;
  logic             w_start;

  logic [IDX_W-1:0] r_idx;
  logic [D_W-1:0]   r_dx;
  logic [D_W-1:0]   r_dy;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [D_W-1:0]   w_dx_nxt;
  logic [D_W-1:0]   w_dy_nxt;
  logic             w_dx_last;
  logic             w_px_last;
  logic             w_boid_last;

  logic [X_W-1:0]   r_sh_x [NUM_BOIDS];
  logic [Y_W-1:0]   r_sh_y [NUM_BOIDS];
  logic [NUM_BOIDS-1:0] r_sh_vld;

  logic [X_W-1:0]   w_bx;
  logic [Y_W-1:0]   w_by;
  logic [XS_W-1:0]  w_px;
  logic [YS_W-1:0]  w_py;
  logic             w_in_view;
  logic [PAW-1:0]   w_pix_addr;

  logic [IDX_W-1:0] r_pos_addr;
  logic [PAW-1:0]   r_wr_addr;
  logic             r_wr_data;
  logic             r_wr_en;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_overrun;

  logic [IDX_W-1:0] w_pos_addr;
  logic [PAW-1:0]   w_wr_addr;
  logic             w_wr_data;
  logic             w_wr_en;
  logic             w_busy;
  logic             w_frame_done;
  logic             w_overrun;

  // Rising-edge detect on the frame boundary level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_se_q <= 1'b0;
    else        r_se_q <= screenEnd;
  end

  assign w_start     = screenEnd & ~r_se_q;
  assign w_dx_last   = (r_dx == D_W'(BOID_SIZE - 1));
  assign w_px_last   = w_dx_last && (r_dy == D_W'(BOID_SIZE - 1));
  assign w_boid_last = (r_idx == IDX_W'(NUM_BOIDS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = (|r_sh_vld) ? S_ERASE : S_FETCH;
      S_ERASE: if (w_px_last && w_boid_last) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_DRAW;
      S_DRAW:  if (w_px_last) w_state_nxt = w_boid_last ? S_DONE : S_FETCH;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Boid index and in-square pixel walk (dy outer, dx inner)
  always_comb begin
    w_idx_nxt = r_idx;
    w_dx_nxt  = r_dx;
    w_dy_nxt  = r_dy;
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        w_dx_nxt  = '0;
        w_dy_nxt  = '0;
      end
      S_ERASE, S_DRAW: begin
        if (!w_dx_last) begin
          w_dx_nxt = r_dx + D_W'(1);
        end else begin
          w_dx_nxt = '0;
          if (w_px_last) begin
            w_dy_nxt  = '0;
            w_idx_nxt = w_boid_last ? '0 : r_idx + IDX_W'(1);
          end else begin
            w_dy_nxt = r_dy + D_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Walk counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
      r_dx  <= '0;
      r_dy  <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      r_dx  <= w_dx_nxt;
      r_dy  <= w_dy_nxt;
    end
  end

  // Shadow table: the position drawn this frame, erased next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_vld <= '0;
      for (int i = 0; i < int'(NUM_BOIDS); i++) begin
        r_sh_x[i] <= '0;
        r_sh_y[i] <= '0;
      end
    end else if (r_state == S_LATCH) begin
      r_sh_x[r_idx]   <= pos_read_x;
      r_sh_y[r_idx]   <= pos_read_y;
      r_sh_vld[r_idx] <= 1'b1;
    end
  end

  // Pixel coordinate, clip test and bitmap address for the current walk step
  always_comb begin
    w_bx       = r_sh_x[r_idx];
    w_by       = r_sh_y[r_idx];
    w_px       = XS_W'(w_bx) + XS_W'(r_dx);
    w_py       = YS_W'(w_by) + YS_W'(r_dy);
    w_in_view  = (w_px < XS_W'(VIDEO_WIDTH)) && (w_py < YS_W'(VIDEO_HEIGHT));
    w_pix_addr = PAW'(w_px) + PAW'(VIDEO_WIDTH) * PAW'(w_py);
  end

  // Output decode; values take effect on the next clock
  always_comb begin
    w_pos_addr   = r_pos_addr;
    w_wr_addr    = '0;
    w_wr_data    = 1'b0;
    w_wr_en      = 1'b0;
    w_busy       = (w_state_nxt != S_IDLE);
    w_frame_done = (r_state == S_DONE);
    w_overrun    = w_start && (r_state != S_IDLE);
    if (w_state_nxt == S_FETCH) w_pos_addr = w_idx_nxt;
    if ((r_state == S_ERASE || r_state == S_DRAW) && w_in_view) begin
      w_wr_en   = 1'b1;
      w_wr_addr = w_pix_addr;
      w_wr_data = (r_state == S_DRAW);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos_addr   <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_pos_addr   <= w_pos_addr;
      r_wr_addr    <= w_wr_addr;
      r_wr_data    <= w_wr_data;
      r_wr_en      <= w_wr_en;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
      r_overrun    <= w_overrun;
    end
  end

  assign pos_read_addr      = r_pos_addr;
  assign boid_write_address = r_wr_addr;
  assign boid_write_data    = r_wr_data;
  assign boid_write_en      = r_wr_en;
  assign busy               = r_busy;
  assign frame_done         = r_frame_done;
  assign overrun            = r_overrun;

endmodule

// File: doc/boid_frame_writer.md
Name: boid_frame_writer

Overview:
- Writer side of the boid pixel bitmap that the VGA display path reads: once per frame, on the rising edge of screenEnd, it erases every boid square drawn in the previous frame, then draws each boid's current position as a square of 1s.
- Boid positions are fetched from the boid position table through a synchronous read port.
- Pixel writes go to the write port of the dual-port boid bitmap RAM; the display side keeps the read port.

Parameters:
- NUM_BOIDS, 16, number of boids drawn per frame (>=1)
- BOID_SIZE, 2, side length of each boid square in pixels (1..8)
- VIDEO_WIDTH, 640, visible width in pixels
- VIDEO_HEIGHT, 480, visible height in pixels
- PIXEL_ADDRESS_WIDTH, 20, bitmap address width

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- screenEnd  in  1  frame-boundary level from the timing generator; a rising edge starts a frame update
- pos_read_addr  out  clog2(NUM_BOIDS) (min 1)  boid index to fetch
- pos_read_x  in  10  boid x (top-left), valid 1 clk after pos_read_addr
- pos_read_y  in  9  boid y (top-left), valid 1 clk after pos_read_addr
- boid_write_address  out  PIXEL_ADDRESS_WIDTH  bitmap write address = x + VIDEO_WIDTH*y
- boid_write_data  out  1  pixel value (0 = erase, 1 = draw)
- boid_write_en  out  1  write strobe, one pixel per clk
- busy  out  1  high from the first ERASE/FETCH cycle until DONE
- frame_done  out  1  one-clk pulse when an update completes
- overrun  out  1  one-clk pulse when a screenEnd rising edge arrives while busy

Behaviour:
- Reset values: all outputs 0; state IDLE; screenEnd edge register 0; all shadow valid bits 0.
- Reset is asynchronous and may assert in any state. It aborts the update; the bitmap may hold partial drawings and is not cleaned up.
- Edge detect: screenEnd is registered on clk. A start occurs on the clk where screenEnd=1 and the registered value is 0. It is acted on only in IDLE; in any other state it pulses overrun for 1 clk and is otherwise ignored.
- State machine:
  - IDLE: on start, go to ERASE if any shadow entry is valid, else go to FETCH.
  - ERASE: walk boid i = 0..NUM_BOIDS-1, then dy = 0..BOID_SIZE-1 (outer), then dx = 0..BOID_SIZE-1 (inner), using the stored shadow (x,y) for boid i. Write data 0. Takes NUM_BOIDS*BOID_SIZE^2 clks, then go to FETCH with i=0.
  - FETCH: drive pos_read_addr=i for 1 clk, then go to LATCH.
  - LATCH: capture pos_read_x/pos_read_y into the shadow entry i and set its valid bit, then go to DRAW.
  - DRAW: walk dy/dx as in ERASE using the latched position. Write data 1; BOID_SIZE^2 clks. After the last pixel: if i < NUM_BOIDS-1, increment i and go to FETCH; else go to DONE.
  - DONE: pulse frame_done for 1 clk, then return to IDLE.
- Write timing: boid_write_en, address and data are registered and change together. Each one-clk en pulse is exactly one pixel write.
- Clipping: pixel (x+dx, y+dy) is written only if x+dx < VIDEO_WIDTH and y+dy < VIDEO_HEIGHT. A clipped pixel still consumes its clk, with boid_write_en=0.
- Arithmetic: compute x+dx at 11 bits and y+dy at 10 bits so the sums cannot wrap. Compute the address at full width.
- Pass ordering: all erases complete before any draw, so overlapping boids are never left half-erased.
- Position changes: the position table may change between frames. Only the value captured in LATCH is used for drawing and for the next frame's erase.
- Update length: total update <= 2 + NUM_BOIDS*(2*BOID_SIZE^2+2) clks. This must fit inside vertical blanking (144000 clks at 100 MHz).

Test Plan:
- First frame after reset: boid 0 at (10,20), size 2, NUM_BOIDS=1; screenEnd rises. Expect no erase writes, then 4 writes of data 1 to addresses 12810, 12811, 13450, 13451; frame_done 1 clk after the last write.
- Second frame: boid 0 moves to (11,20). Expect 4 writes of data 0 (12810, 12811, 13450, 13451), then 4 writes of data 1 (12811, 12812, 13451, 13452), in that order.
- Edge clipping: boid at (639,479). Expect exactly one write, to address 307199; the other 3 pixel clks have boid_write_en=0; no write address is >= 307200.
- Overrun: hold a second screenEnd rising edge during the DRAW of a NUM_BOIDS=16 update. Expect an overrun pulse, the current update to finish normally, and no restart.
- Reset mid-operation: drop reset during ERASE. Expect all outputs 0 asynchronously. The next screenEnd starts with no erase, because the valid bits are cleared.
- Level held: hold screenEnd high for 4 clks. Expect exactly one update and no overrun.
